// File: rtl/riscv_pkg.sv
// Shared RV32I/RV64I decode definitions: immediate format tags, base opcodes, shift funct3 codes
// and the skid-buffer occupancy states used by the immediate-generator pipe.
package riscv_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_SHAMT = 3'd2,
        FMT_S     = 3'd3,
        FMT_B     = 3'd4,
        FMT_U     = 3'd5,
        FMT_J     = 3'd6
    } imm_fmt_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    // All base opcodes end in 2'b11, so the distinguishing bits are [6:2].
    function automatic logic [4:0] opc_key(input logic [6:0] opc);
        return opc[6:2];
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Producer/consumer bundle of the immediate-generator pipe: valid/ready instruction input and
// valid/ready decoded-immediate output. The slave modport is the pipe's view, master the peer's.
interface imm_gen_pipe_if #(parameter int XLEN = 32);
    import riscv_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_imm;
    imm_fmt_t        out_fmt;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_inst, out_imm, out_fmt, out_illegal
    );

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_inst, out_imm, out_fmt, out_illegal
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decode (I/S/B/U/J/shamt), extended to XLEN; zero latency, no state.
// IMM_GEN_ILLEGAL_EN adds illegal detection on unknown opcodes or inst[1:0] != 2'b11.
module imm_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_inst,
    output logic [XLEN-1:0] o_imm,
    output imm_fmt_t        o_fmt,
    output logic            o_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode: XLEN must be 32 or 64");
    end

    logic [31:0] w_imm32;
    logic [31:0] w_shamt32;
    imm_fmt_t    w_fmt;
    logic [2:0]  w_funct3;

    assign w_funct3 = i_inst[14:12];

    // RV64 shifts take one more shamt bit; funct7 is never part of the immediate.
    if (XLEN == 64) begin : g_sh64
        assign w_shamt32 = {26'd0, i_inst[25:20]};
    end else begin : g_sh32
        assign w_shamt32 = {27'd0, i_inst[24:20]};
    end

    always_comb begin
        w_imm32 = '0;
        w_fmt   = FMT_NONE;
        case (opc_key(i_inst[6:0]))
            opc_key(OP_LOAD), opc_key(OP_JALR): begin
                w_fmt   = FMT_I;
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            opc_key(OP_IMM): begin
                if (w_funct3 == F3_SLLI || w_funct3 == F3_SRXI) begin
                    w_fmt   = FMT_SHAMT;
                    w_imm32 = w_shamt32;
                end else begin
                    w_fmt   = FMT_I;
                    w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
                end
            end
            opc_key(OP_STORE): begin
                w_fmt   = FMT_S;
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            end
            opc_key(OP_BRANCH): begin
                w_fmt   = FMT_B;
                w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                           i_inst[11:8], 1'b0};
            end
            opc_key(OP_LUI), opc_key(OP_AUIPC): begin
                w_fmt   = FMT_U;
                w_imm32 = {i_inst[31:12], 12'b0};
            end
            opc_key(OP_JAL): begin
                w_fmt   = FMT_J;
                w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                           i_inst[30:21], 1'b0};
            end
            default: ;
        endcase
`ifdef IMM_GEN_ILLEGAL_EN
        if (i_inst[1:0] != 2'b11) begin
            w_fmt   = FMT_NONE;
            w_imm32 = '0;
        end
`endif
    end

    // Every 32-bit form already carries inst[31] in its MSB, so one signed widen finishes the job.
    assign o_imm = XLEN'($signed(w_imm32));
    assign o_fmt = w_fmt;

`ifdef IMM_GEN_ILLEGAL_EN
    assign o_illegal = (w_fmt == FMT_NONE);
`else
    logic w_unused_low_bits;
    assign w_unused_low_bits = ^i_inst[1:0];
    assign o_illegal = 1'b0;
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode captured on accept, outputs 1 cycle later, 1/cycle throughput.
// Two-entry skid buffer; in_ready depends only on the state register (IMM_GEN_ILLEGAL_EN: illegal flag).
module imm_gen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        imm_fmt_t        fmt;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] w_dec_imm;
    imm_fmt_t        w_dec_fmt;
    logic            w_dec_illegal;
    entry_t          w_new;

    entry_t      r_main;
    entry_t      r_skid;
    skid_state_t r_state;
    skid_state_t w_state_nxt;

    logic w_acc;
    logic w_pop;
    logic w_main_ld;
    logic w_main_from_skid;
    logic w_skid_ld;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .i_inst    (bus.in_inst),
        .o_imm     (w_dec_imm),
        .o_fmt     (w_dec_fmt),
        .o_illegal (w_dec_illegal)
    );

    assign w_new = {bus.in_inst, w_dec_imm, w_dec_fmt, w_dec_illegal};

    // A flushing cycle never accepts, so the offered instruction is simply dropped.
    assign w_acc = bus.in_valid && (r_state != SKID_TWO) && !flush;
    assign w_pop = (r_state != SKID_EMPTY) && bus.out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_ld        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_ld        = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt = SKID_ONE;
                    w_main_ld   = 1'b1;
                end
            end
            SKID_ONE: begin
                if (w_acc && w_pop) begin
                    w_main_ld = 1'b1;
                end else if (w_acc) begin
                    w_state_nxt = SKID_TWO;
                    w_skid_ld   = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (w_pop) begin
                    w_state_nxt      = SKID_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = SKID_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt      = SKID_EMPTY;
            w_main_ld        = 1'b0;
            w_main_from_skid = 1'b0;
            w_skid_ld        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SKID_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_main_ld) begin
                r_main <= w_new;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_ld) begin
                r_skid <= w_new;
            end
        end
    end

    assign bus.in_ready    = (r_state != SKID_TWO);
    assign bus.out_valid   = (r_state != SKID_EMPTY);
    assign bus.out_inst    = r_main.inst;
    assign bus.out_imm     = r_main.imm;
    assign bus.out_fmt     = r_main.fmt;
    assign bus.out_illegal = r_main.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed vector table, backpressure/flush/reset sequences, random traffic
// against an arithmetic decode model and a FIFO occupancy model.
module tb_imm_gen_pipe;
    import riscv_pkg::*;

    localparam int XLEN = 32;
`ifdef IMM_GEN_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic flush;

    imm_gen_pipe_if #(.XLEN(XLEN)) bus ();

    imm_gen_pipe #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] q[$];
    logic [31:0] popped[$];

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t vt[15];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Immediate values rebuilt from field weights with signed integer arithmetic.
    task automatic ref_dec(input logic [31:0] inst, output logic [XLEN-1:0] imm,
                           output logic [2:0] fmt, output logic ill);
        longint u;
        longint v;
        longint f3;
        logic [63:0] t;
        logic [6:0] opc;
        u   = {32'd0, inst};
        v   = 0;
        fmt = 3'd0;
        f3  = (u >> 12) & 7;
        opc = {inst[6:2], 2'b11};
        case (opc)
            7'h03, 7'h67: begin
                fmt = 3'd1;
                v = u >> 20;
                if (v >= 2048) v -= 4096;
            end
            7'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    fmt = 3'd2;
                    v = (u >> 20) % XLEN;
                end else begin
                    fmt = 3'd1;
                    v = u >> 20;
                    if (v >= 2048) v -= 4096;
                end
            end
            7'h23: begin
                fmt = 3'd3;
                v = (u >> 25) * 32 + ((u >> 7) & 31);
                if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                fmt = 3'd4;
                v = ((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048
                  + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h37, 7'h17: begin
                fmt = 3'd5;
                v = u & 64'hFFFF_F000;
                if (v >= 64'sd2147483648) v -= 64'sd4294967296;
            end
            7'h6F: begin
                fmt = 3'd6;
                v = ((u >> 31) & 1) * 1048576 + ((u >> 12) & 255) * 4096
                  + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            default: ;
        endcase
        if (ILL_EN && inst[1:0] != 2'b11) begin
            fmt = 3'd0;
            v = 0;
        end
        ill = ILL_EN && (fmt == 3'd0);
        t   = v;
        imm = t[XLEN-1:0];
    endtask

    // Called just after a falling edge: check settled outputs, drive the next edge, update the model.
    task automatic cycle(input logic vld, input logic [31:0] inst, input logic ordy, input logic fl);
        logic [XLEN-1:0] e_imm;
        logic [2:0]      e_fmt;
        logic            e_ill;
        logic            acc;
        logic            pop;
        check("out_valid", 128'(bus.out_valid), 128'(q.size() != 0));
        check("in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
        if (q.size() != 0) begin
            ref_dec(q[0], e_imm, e_fmt, e_ill);
            check("head", 128'({bus.out_inst, bus.out_imm, bus.out_fmt, bus.out_illegal}),
                  128'({q[0], e_imm, e_fmt, e_ill}));
        end
        bus.in_valid  = vld;
        bus.in_inst   = inst;
        bus.out_ready = ordy;
        flush         = fl;
        acc = vld && (q.size() < 2) && !fl && !reset;
        pop = (q.size() != 0) && ordy && !reset;
        if (pop) begin
            popped.push_back(q[0]);
            void'(q.pop_front());
        end
        if (reset || fl) q.delete();
        else if (acc) q.push_back(inst);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ri;
        logic [6:0]  ops[8];
        int          k;
        int          n;

        vt[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0};
        vt[1]  = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0};
        vt[2]  = '{32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd4, 1'b0};
        vt[3]  = '{32'h123450B7, 64'h0000_0000_1234_5000, 3'd5, 1'b0};
        vt[4]  = '{32'h001000EF, 64'h0000_0000_0000_0800, 3'd6, 1'b0};
        vt[5]  = '{32'h4030D093, 64'h0000_0000_0000_0003, 3'd2, 1'b0};
        vt[6]  = '{32'h7FF00013, 64'h0000_0000_0000_07FF, 3'd1, 1'b0};
        vt[7]  = '{32'h80002003, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0};
        vt[8]  = '{32'hFFFFF017, 64'hFFFF_FFFF_FFFF_F000, 3'd5, 1'b0};
        vt[9]  = '{32'h8000006F, 64'hFFFF_FFFF_FFF0_0000, 3'd6, 1'b0};
        vt[10] = '{32'h03F01013, (XLEN == 64) ? 64'd63 : 64'd31, 3'd2, 1'b0};
        vt[11] = '{32'h0000007F, 64'd0, 3'd0, ILL_EN};
        vt[12] = '{32'h00000463, 64'd8, 3'd4, 1'b0};
        vt[13] = '{32'h00C08067, 64'd12, 3'd1, 1'b0};
        vt[14] = '{32'h00112423, 64'd8, 3'd3, 1'b0};

        ops = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("reset_outputs",
              128'({bus.out_valid, bus.out_inst, bus.out_imm, bus.out_fmt, bus.out_illegal}), 128'd0);
        reset = 1'b0;
        check("reset_in_ready", 128'(bus.in_ready), 128'd1);

        // Back-to-back stream: each vector must appear the cycle after it is offered.
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, vt[i].inst, 1'b1, 1'b0);
            check($sformatf("vec%0d", i),
                  128'({bus.out_valid, bus.out_inst, bus.out_imm, bus.out_fmt, bus.out_illegal}),
                  128'({1'b1, vt[i].inst, vt[i].imm[XLEN-1:0], vt[i].fmt, vt[i].ill}));
        end
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        // Backpressure: two accepted, third held until the consumer drains.
        popped.delete();
        cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200113, 1'b0, 1'b0);
        check("bp_in_ready_low", 128'(bus.in_ready), 128'd0);
        cycle(1'b1, 32'h00300193, 1'b0, 1'b0);
        check("bp_head_held", 128'(bus.out_inst), 128'(32'h00100093));
        cycle(1'b1, 32'h00300193, 1'b1, 1'b0);
        cycle(1'b1, 32'h00300193, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        check("bp_drained", 128'(bus.out_valid), 128'd0);
        check("bp_count", 128'(popped.size()), 128'd3);
        if (popped.size() == 3) begin
            check("bp_order0", 128'(popped[0]), 128'(32'h00100093));
            check("bp_order1", 128'(popped[1]), 128'(32'h00200113));
            check("bp_order2", 128'(popped[2]), 128'(32'h00300193));
        end

        // Flush from TWO with a simultaneous offer.
        cycle(1'b1, 32'h00400213, 1'b0, 1'b0);
        cycle(1'b1, 32'h00500293, 1'b0, 1'b0);
        cycle(1'b1, 32'h00600313, 1'b0, 1'b1);
        check("flush_valid", 128'(bus.out_valid), 128'd0);
        check("flush_in_ready", 128'(bus.in_ready), 128'd1);
        repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b0);
        check("flush_no_emit", 128'(bus.out_valid), 128'd0);

        // Reset while holding one entry.
        cycle(1'b1, 32'h00700393, 1'b0, 1'b0);
        check("one_valid", 128'(bus.out_valid), 128'd1);
        reset = 1'b1;
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        check("rst_mid_outputs",
              128'({bus.out_valid, bus.out_inst, bus.out_imm, bus.out_fmt, bus.out_illegal}), 128'd0);
        check("rst_mid_in_ready", 128'(bus.in_ready), 128'd1);
        reset = 1'b0;

        // All-zero word: low bits 00 decide between illegal and a plain load.
        cycle(1'b1, 32'h00000000, 1'b1, 1'b0);
        check("zero_inst", 128'({bus.out_illegal, bus.out_fmt, bus.out_imm}),
              ILL_EN ? 128'({1'b1, 3'd0, {XLEN{1'b0}}}) : 128'({1'b0, 3'd1, {XLEN{1'b0}}}));
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        // Random traffic with random stalls and occasional flushes.
        for (int c = 0; c < 3000; c++) begin
            ri = $urandom;
            k  = $urandom_range(0, 8);
            if (k < 8) ri[6:0] = ops[k];
            if ($urandom_range(0, 7) == 0) ri[1:0] = 2'($urandom_range(0, 2));
            cycle($urandom_range(0, 3) != 0, ri, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 63) == 0);
        end
        n = 0;
        while (q.size() != 0 && n < 10) begin
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
            n++;
        end
        check("final_empty", 128'(bus.out_valid), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
